// File: rtl/data_sync_tx.sv
`default_nettype none
// ============================================================================
// Module      : data_sync_tx
// Description : Source-domain sender for the multi-bit bus synchronizer.
//               Holds a captured word on unsync_bus and runs a 4-phase
//               req/ack handshake against the synchronized destination ack.
// Revision    : 1.0 - initial release
// ============================================================================
module data_sync_tx #(
    parameter int BUS_WIDTH = 8,
    parameter int NUM_STAGE = 2,
    parameter int TIMEOUT   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 ack_in_i,
    output logic [BUS_WIDTH-1:0] unsync_bus_o,
    output logic                 bus_enable_o,
    output logic                 busy_o,
    output logic                 tx_done_o,
    output logic                 tx_err_o
);

    localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam bit               TO_EN    = (TIMEOUT != 0);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [BUS_WIDTH-1:0] bus_q, bus_d;
    logic                 en_q, en_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_STAGE-1:0] ack_sync_q;
    logic                 ack_s;

    // Only the last stage of the chain is ever looked at.
    assign ack_s = ack_sync_q[NUM_STAGE-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[NUM_STAGE-2:0], ack_in_i};
        end
    end

    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        en_d    = en_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = (cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (in_valid_i) begin
                    bus_d   = in_data_i;
                    en_d    = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    en_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_RELEASE;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    en_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    state_d = ST_IDLE;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                en_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Each phase gets its own full timeout budget.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bus_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            en_q    <= en_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready_o   = (state_q == ST_IDLE);
    assign busy_o       = ~in_ready_o;
    assign unsync_bus_o = bus_q;
    assign bus_enable_o = en_q;
    assign tx_done_o    = done_q;
    assign tx_err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_sync_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_sync_tx
// Description : Directed self-checking bench for data_sync_tx with a
//               slow-clock loopback destination model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sync_tx;

    localparam int BUS_WIDTH = 8;
    localparam int NUM_STAGE = 2;
    localparam int TIMEOUT   = 16;

    logic                 clk, dclk, rst_n;
    logic [BUS_WIDTH-1:0] in_data;
    logic                 in_valid, in_ready, ack_in;
    logic [BUS_WIDTH-1:0] unsync_bus;
    logic                 bus_enable, busy, tx_done, tx_err;

    logic                 ack_man, use_loop;
    logic                 d1, d2, d3;
    logic [7:0]           dq[$];

    int n_tests = 0;
    int n_fail  = 0;

    data_sync_tx #(
        .BUS_WIDTH (BUS_WIDTH),
        .NUM_STAGE (NUM_STAGE),
        .TIMEOUT   (TIMEOUT)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .ack_in_i     (ack_in),
        .unsync_bus_o (unsync_bus),
        .bus_enable_o (bus_enable),
        .busy_o       (busy),
        .tx_done_o    (tx_done),
        .tx_err_o     (tx_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Destination clock runs 3x slower, offset from source edges.
    initial begin
        dclk = 1'b0;
        #2;
        forever #15 dclk = ~dclk;
    end

    always @(posedge dclk) begin
        d1 <= bus_enable;
        d2 <= d1;
        d3 <= d2;
        if (d2 && !d3) dq.push_back(unsync_bus);
    end

    assign ack_in = use_loop ? d2 : ack_man;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] d, input int rise_at, input bit drop_on_done,
                        input bit hold_valid, output int done_c, output int err_c,
                        output int idle_c, output int be_c, output bit stable);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        stable   = (unsync_bus == d) && bus_enable;
        done_c   = -1;
        err_c    = -1;
        idle_c   = -1;
        be_c     = 0;
        if (rise_at == 0) ack_man = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            in_data = 8'($urandom);
            if (hold_valid) in_valid = 1'b1;
            if (unsync_bus != d) stable = 1'b0;
            if (bus_enable) be_c++;
            if (tx_done) done_c = c;
            if (tx_err) err_c = c;
            if (c == rise_at) ack_man = 1'b1;
            if (tx_done && drop_on_done) ack_man = 1'b0;
            if (in_ready) begin
                in_valid = 1'b0;
                idle_c   = c;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int dc, ec, ic, bc;
        bit st;
        logic [7:0] exp_q[$];
        int bad, ndone, nerr, nmis;

        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        ack_man  = 1'b0;
        use_loop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", in_ready, 1);
        chk("rst bus_enable", bus_enable, 0);
        chk("rst unsync_bus", unsync_bus, 0);
        chk("rst done/err", {tx_done, tx_err}, 0);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of REQ.
        @(posedge clk); #1;
        in_data  = 8'h5A;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t1 req enable", bus_enable, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t1 async enable", bus_enable, 0);
        chk("t1 async bus", unsync_bus, 0);
        chk("t1 async ready/busy", {in_ready, busy}, 2'b10);
        chk("t1 async done/err", {tx_done, tx_err}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single word, ack rising 3 cycles after enable.
        xfer(8'hA5, 3, 1'b1, 1'b0, dc, ec, ic, bc, st);
        chk("t2 done cycle", dc, 6);
        chk("t2 idle cycle", ic, 9);
        chk("t2 enable cycles", bc, 5);
        chk("t2 no err", ec, -1);
        chk("t2 bus stable", st, 1);
        chk("t2 bus value", unsync_bus, 8'hA5);

        // REQ timeout with ack stuck low.
        repeat (4) @(posedge clk);
        #1;
        xfer(8'hC3, -1, 1'b0, 1'b0, dc, ec, ic, bc, st);
        chk("t4 err cycle", ec, 16);
        chk("t4 enable cycles", bc, 15);
        chk("t4 idle cycle", ic, 17);
        chk("t4 no done", dc, -1);
        chk("t4 bus stable", st, 1);

        // Stuck-high ack times out in RELEASE.
        repeat (4) @(posedge clk);
        #1;
        xfer(8'h3C, 0, 1'b0, 1'b0, dc, ec, ic, bc, st);
        chk("t5 done cycle", dc, 3);
        chk("t5 err cycle", ec, 19);
        chk("t5 idle cycle", ic, 19);
        chk("t5 bus value", unsync_bus, 8'h3C);

        // Stale high ack at capture: REQ exits on the first cycle.
        xfer(8'h99, -1, 1'b1, 1'b0, dc, ec, ic, bc, st);
        chk("stale done cycle", dc, 1);
        chk("stale idle cycle", ic, 4);
        chk("stale no err", ec, -1);

        // Back-to-back words through the loopback destination.
        repeat (10) @(posedge clk);
        #1;
        dq.delete();
        use_loop = 1'b1;
        for (int w = 1; w <= 3; w++) begin
            xfer(8'(w), -1, 1'b0, 1'b0, dc, ec, ic, bc, st);
            chk("t3 done seen", (dc > 0), 1);
            chk("t3 no err", ec, -1);
            chk("t3 returned idle", (ic > dc), 1);
        end
        repeat (10) @(posedge clk);
        #1;
        chk("t3 words received", dq.size(), 3);
        if (dq.size() == 3) begin
            chk("t3 word0", dq[0], 8'h01);
            chk("t3 word1", dq[1], 8'h02);
            chk("t3 word2", dq[2], 8'h03);
        end

        // Random transfers with in_data toggling (and in_valid held) while busy.
        dq.delete();
        bad   = 0;
        ndone = 0;
        nerr  = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            exp_q.push_back(d);
            xfer(d, -1, 1'b0, (i % 2) == 1, dc, ec, ic, bc, st);
            if (!st || ic < 0) bad++;
            if (dc > 0) ndone++;
            if (ec > 0) nerr++;
        end
        repeat (10) @(posedge clk);
        #1;
        nmis = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i >= dq.size() || dq[i] != exp_q[i]) nmis++;
        end
        chk("t6 unstable transfers", bad, 0);
        chk("t6 done count", ndone, 1000);
        chk("t6 err count", nerr, 0);
        chk("t6 words received", dq.size(), 1000);
        chk("t6 word mismatches", nmis, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
